// File: rtl/vga_pkg.sv
// Shared widths, entry layout and read-ordering state encoding for the
// CPU write FIFO between the graphics write stage and the memory arbiter.
package vga_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int ADDR_W    = 20;
    localparam int PLANE_W   = 8;
    localparam int DATA_W    = 32;
    localparam int ENTRY_W   = ADDR_W + PLANE_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [PLANE_W-1:0] plane_en;
        logic [DATA_W-1:0]  data;
    } ff_entry_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DRAIN = 2'd1,
        RD_GO    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/cpu_ff_ram.sv
// Entry storage for the CPU write FIFO: one synchronous write port and one
// asynchronous read port so the head entry is visible without a read cycle.
module cpu_ff_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 60,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vga_cpu_wr_fifo.sv
// CPU write FIFO: buffers host writes for the memory arbiter and holds off
// graphics reads (rd_go) until every earlier write has been retired.
module vga_cpu_wr_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AFULL_LVL = 6,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                t_mem_clk,
    input  logic                h_reset,
    input  logic                g_memwr,
    input  logic [ADDR_W-1:0]   val_mrdwr_addr,
    input  logic [PLANE_W-1:0]  fin_plane_sel,
    input  logic [DATA_W-1:0]   g_graph_data_out,
    input  logic                g_memrd,
    input  logic                wr_gnt,
    output logic                m_cpu_ff_full,
    output logic                ff_afull,
    output logic                ff_empty,
    output logic [PTR_W:0]      ff_count,
    output logic                wr_req,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PLANE_W-1:0]  wr_plane_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                rd_go,
    output logic                ff_ovfl,
    output rd_state_t           rd_state
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_C = (PTR_W+1)'(AFULL_LVL);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    ff_entry_t        wr_entry;
    ff_entry_t        head;
    rd_state_t        rd_state_nxt;

    // Flags decode from the registered count only, never from this cycle's strobes.
    assign ff_empty      = (ff_count == '0);
    assign m_cpu_ff_full = (ff_count == DEPTH_C);
    assign ff_afull      = (ff_count >= AFULL_C);
    assign wr_req        = !ff_empty;

    // Handshake: an entry retires when wr_req and wr_gnt are both high in a
    // cycle; wr_gnt alone is ignored. A push is taken if there is room or the
    // head leaves in the same cycle.
    assign pop  = wr_req & wr_gnt;
    assign push = g_memwr & (!m_cpu_ff_full | pop);

    assign wr_entry = '{addr: val_mrdwr_addr, plane_en: fin_plane_sel, data: g_graph_data_out};

    cpu_ff_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk   (t_mem_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Stale storage is masked so the head fields read zero when empty.
    assign wr_addr     = wr_req ? head.addr     : '0;
    assign wr_plane_en = wr_req ? head.plane_en : '0;
    assign wr_data     = wr_req ? head.data     : '0;

    always_ff @(posedge t_mem_clk) begin
        if (h_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ff_count <= '0;
            ff_ovfl  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   ff_count <= ff_count + 1'b1;
                2'b01:   ff_count <= ff_count - 1'b1;
                default: ff_count <= ff_count;
            endcase
            if (g_memwr && !push) ff_ovfl <= 1'b1;
        end
    end

    always_ff @(posedge t_mem_clk) begin
        if (h_reset) rd_state <= RD_IDLE;
        else         rd_state <= rd_state_nxt;
    end

    // A write pushed in the same cycle must retire before the read may go.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: begin
                if (g_memrd) rd_state_nxt = (ff_empty && !push) ? RD_GO : RD_DRAIN;
            end
            RD_DRAIN: begin
                if (!g_memrd)                rd_state_nxt = RD_IDLE;
                else if (ff_empty && !push)  rd_state_nxt = RD_GO;
            end
            RD_GO: begin
                if (!g_memrd) rd_state_nxt = RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    assign rd_go = (rd_state == RD_GO);

endmodule

// File: tb/tb_vga_cpu_wr_fifo.sv
// Bench for vga_cpu_wr_fifo: directed vector table for the corner sequences,
// then random traffic, all checked against a queue-based reference model.
module tb_vga_cpu_wr_fifo;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        clk = 1'b0;
    logic        h_reset = 1'b1;
    logic        g_memwr = 1'b0;
    logic [19:0] val_mrdwr_addr = '0;
    logic [7:0]  fin_plane_sel = '0;
    logic [31:0] g_graph_data_out = '0;
    logic        g_memrd = 1'b0;
    logic        wr_gnt = 1'b0;
    logic        m_cpu_ff_full, ff_afull, ff_empty, wr_req, rd_go, ff_ovfl;
    logic [3:0]  ff_count;
    logic [19:0] wr_addr;
    logic [7:0]  wr_plane_en;
    logic [31:0] wr_data;
    logic [1:0]  rd_state;

    vga_cpu_wr_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .t_mem_clk        (clk),
        .h_reset          (h_reset),
        .g_memwr          (g_memwr),
        .val_mrdwr_addr   (val_mrdwr_addr),
        .fin_plane_sel    (fin_plane_sel),
        .g_graph_data_out (g_graph_data_out),
        .g_memrd          (g_memrd),
        .wr_gnt           (wr_gnt),
        .m_cpu_ff_full    (m_cpu_ff_full),
        .ff_afull         (ff_afull),
        .ff_empty         (ff_empty),
        .ff_count         (ff_count),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_plane_en      (wr_plane_en),
        .wr_data          (wr_data),
        .rd_go            (rd_go),
        .ff_ovfl          (ff_ovfl),
        .rd_state         (rd_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entry queue, sticky overflow, read-permission flag
    logic [59:0] exp_q[$];
    logic        m_ovfl = 1'b0;
    logic        m_go   = 1'b0;

    typedef struct {
        logic w, g, r, rs;
        int   cnt;
        logic [1:0] st;
        logic go, ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic w, input logic [59:0] e, input logic g,
                              input logic r, input logic rs);
        logic pop, push;
        if (rs) begin
            exp_q.delete();
            m_ovfl = 1'b0;
            m_go   = 1'b0;
        end else begin
            pop  = (exp_q.size() > 0) && g;
            push = w && (exp_q.size() < DEPTH || pop);
            if (w && !push) m_ovfl = 1'b1;
            if (!r) m_go = 1'b0;
            else if (!m_go && exp_q.size() == 0 && !push) m_go = 1'b1;
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(e);
        end
    endtask

    task automatic model_check();
        logic [59:0] hd;
        int n;
        n  = exp_q.size();
        hd = (n > 0) ? exp_q[0] : 60'd0;
        chk("ff_count", 64'(ff_count), 64'(n));
        chk("ff_empty", 64'(ff_empty), 64'(n == 0));
        chk("ff_full",  64'(m_cpu_ff_full), 64'(n == DEPTH));
        chk("ff_afull", 64'(ff_afull), 64'(n >= AFULL));
        chk("wr_req",   64'(wr_req), 64'(n > 0));
        chk("head",     64'({wr_addr, wr_plane_en, wr_data}), 64'(hd));
        chk("rd_go",    64'(rd_go), 64'(m_go));
        chk("ff_ovfl",  64'(ff_ovfl), 64'(m_ovfl));
    endtask

    // Driver: apply one cycle of inputs, advance the model, sample #1 after the edge
    task automatic do_cycle(input logic w, input logic [59:0] e, input logic g,
                            input logic r, input logic rs);
        g_memwr = w;
        {val_mrdwr_addr, fin_plane_sel, g_graph_data_out} = e;
        wr_gnt  = g;
        g_memrd = r;
        h_reset = rs;
        model_step(w, e, g, r, rs);
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic add_v(input logic w, g, r, rs, input int cnt, input logic [1:0] st,
                         input logic go, ov);
        vec_t v;
        v.w = w; v.g = g; v.r = r; v.rs = rs;
        v.cnt = cnt; v.st = st; v.go = go; v.ov = ov;
        vecs.push_back(v);
    endtask

    function automatic logic [59:0] gen_entry(input int i);
        logic [19:0] a;
        logic [7:0]  p;
        logic [31:0] d;
        a = 20'(i * 16);
        p = (i == 1) ? 8'h0F : 8'(i);
        d = (i == 1) ? 32'hDEADBEEF : {16'hA5A5, 16'(i)};
        return {a, p, d};
    endfunction

    initial begin
        logic w, g, r, rs;
        logic [59:0] e;

        // Reset, single push held without grant, fill, overflow drop
        add_v(0,0,0,1, 0,0,0,0);
        add_v(1,0,0,0, 1,0,0,0);
        for (int k = 0; k < 5; k++) add_v(0,0,0,0, 1,0,0,0);
        for (int k = 2; k <= 8; k++) add_v(1,0,0,0, k,0,0,0);
        add_v(1,0,0,0, 8,0,0,1);
        // Push with pop at full, then drain across the pointer wrap
        add_v(1,1,0,0, 8,0,0,1);
        for (int k = 7; k >= 0; k--) add_v(0,1,0,0, k,0,0,1);
        add_v(0,1,0,0, 0,0,0,1);
        // Read waits for three queued writes to drain
        add_v(0,0,0,1, 0,0,0,0);
        for (int k = 1; k <= 3; k++) add_v(1,0,0,0, k,0,0,0);
        add_v(0,1,1,0, 2,1,0,0);
        add_v(0,1,1,0, 1,1,0,0);
        add_v(0,1,1,0, 0,1,0,0);
        add_v(0,1,1,0, 0,2,1,0);
        add_v(0,0,1,0, 0,2,1,0);
        add_v(1,0,1,0, 1,2,1,0);
        add_v(0,0,0,0, 1,0,0,0);
        add_v(0,1,0,0, 0,0,0,0);
        // Read requested on empty FIFO with a simultaneous push
        add_v(0,0,0,1, 0,0,0,0);
        add_v(1,0,1,0, 1,1,0,0);
        add_v(0,1,1,0, 0,1,0,0);
        add_v(0,0,1,0, 0,2,1,0);
        add_v(0,0,0,0, 0,0,0,0);
        // Reset mid-drain with five entries queued
        add_v(0,0,0,1, 0,0,0,0);
        for (int k = 1; k <= 5; k++) add_v(1,0,0,0, k,0,0,0);
        add_v(1,0,1,0, 6,1,0,0);
        add_v(1,1,1,1, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_cycle(vecs[i].w, gen_entry(i), vecs[i].g, vecs[i].r, vecs[i].rs);
            chk($sformatf("v%0d.count", i), 64'(ff_count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d.state", i), 64'(rd_state), 64'(vecs[i].st));
            chk($sformatf("v%0d.rd_go", i), 64'(rd_go), 64'(vecs[i].go));
            chk($sformatf("v%0d.ovfl", i),  64'(ff_ovfl), 64'(vecs[i].ov));
        end

        // Random traffic against the model
        r = 1'b0;
        do_cycle(0, 60'd0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            w  = ($urandom_range(0, 9) < 6);
            g  = ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 15) == 0) r = !r;
            rs = ($urandom_range(0, 299) == 0);
            e  = {20'($urandom), 8'($urandom), 32'($urandom)};
            do_cycle(w, e, g, r, rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
